// File: rtl/mem_bus_arbiter.sv
// Two-port arbiter/sequencer for a shared single-port memory bus.
// Each transaction runs IDLE -> ACCESS -> DONE; all bus controls are registered.
module mem_bus_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 15,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned FIXED_PRIORITY = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    output logic                  ack0,
    output logic [DATA_WIDTH-1:0] rdata0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  ack1,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  mem_we,
    output logic                  mem_oe,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    inout  wire  [DATA_WIDTH-1:0] mem_data
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;

    logic                  grant_q;
    logic                  we_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  last_grant;

    logic                  grant_nxt;
    logic                  we_nxt;
    logic [DATA_WIDTH-1:0] wdata_nxt;
    logic                  last_grant_nxt;
    logic                  mem_we_nxt;
    logic                  mem_oe_nxt;
    logic [ADDR_WIDTH-1:0] mem_addr_nxt;
    logic                  ack0_nxt;
    logic                  ack1_nxt;
    logic [DATA_WIDTH-1:0] rdata0_nxt;
    logic [DATA_WIDTH-1:0] rdata1_nxt;

    logic                  any_req_c;
    logic                  sel1_c;
    logic                  sel_we_c;

    // Port 1 wins when alone, or on a tie under round-robin when port 0 was granted last.
    assign any_req_c = req0 | req1;
    assign sel1_c    = req1 & (~req0 | ((FIXED_PRIORITY == 32'd0) & ~last_grant));
    assign sel_we_c  = sel1_c ? we1 : we0;

    // Write data is driven only while the registered write strobe is high.
    assign mem_data = mem_we ? wdata_q : {DATA_WIDTH{1'bz}};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (any_req_c) state_nxt = ST_ACCESS;
            ST_ACCESS: state_nxt = ST_DONE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        grant_nxt      = grant_q;
        we_nxt         = we_q;
        wdata_nxt      = wdata_q;
        last_grant_nxt = last_grant;
        mem_we_nxt     = mem_we;
        mem_oe_nxt     = mem_oe;
        mem_addr_nxt   = mem_addr;
        ack0_nxt       = 1'b0;
        ack1_nxt       = 1'b0;
        rdata0_nxt     = rdata0;
        rdata1_nxt     = rdata1;
        case (state)
            ST_IDLE: begin
                if (any_req_c) begin
                    grant_nxt      = sel1_c;
                    last_grant_nxt = sel1_c;
                    we_nxt         = sel_we_c;
                    wdata_nxt      = sel1_c ? wdata1 : wdata0;
                    mem_addr_nxt   = sel1_c ? addr1 : addr0;
                    mem_we_nxt     = sel_we_c;
                    mem_oe_nxt     = ~sel_we_c;
                end
            end
            ST_ACCESS: begin
                mem_we_nxt = 1'b0;
                mem_oe_nxt = 1'b0;
                if (grant_q) begin
                    ack1_nxt = 1'b1;
                    if (!we_q) rdata1_nxt = mem_data;
                end else begin
                    ack0_nxt = 1'b1;
                    if (!we_q) rdata0_nxt = mem_data;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grant_q    <= 1'b0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            last_grant <= 1'b1;
            mem_we     <= 1'b0;
            mem_oe     <= 1'b0;
            mem_addr   <= '0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
        end else begin
            grant_q    <= grant_nxt;
            we_q       <= we_nxt;
            wdata_q    <= wdata_nxt;
            last_grant <= last_grant_nxt;
            mem_we     <= mem_we_nxt;
            mem_oe     <= mem_oe_nxt;
            mem_addr   <= mem_addr_nxt;
            ack0       <= ack0_nxt;
            ack1       <= ack1_nxt;
            rdata0     <= rdata0_nxt;
            rdata1     <= rdata1_nxt;
        end
    end

endmodule
